change_event_counter: RTL and testbench

Clocked, parametrised successor to the event-semantics demonstrator. Watches a `WIDTH`-bit input bus and maintains three chained event counters. Counter B counts input changes. Counter C counts input changes or B changes. Counter D counts B changes or C changes. Adds enable, synchronous clear, wrap/saturate mode, atomic snapshot readout and optional overflow flags. Used as a reference event monitor in simulation-semantics labs and as an activity counter on observed buses.

---
 rtl/change_event_counter_if.sv | 32 +++
 rtl/change_event_counter.sv | 155 +++++++++++++++
 tb/tb_change_event_counter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/change_event_counter_if.sv
// change_event_counter_if
//   Bundles the control inputs and result outputs of change_event_counter.
//   master: drives en/clr/i/snap, observes results (testbench or host).
//   slave : the counter itself.
//   Signals: en, clr, snap, i[WIDTH], y[CNT_W], snap_b/c/d[CNT_W],
//            snap_vld, quiet, ovf[3] ({D,C,B} sticky overflow).
interface change_event_counter_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             en;
    logic             clr;
    logic             snap;
    logic [WIDTH-1:0] i;
    logic [CNT_W-1:0] y;
    logic [CNT_W-1:0] snap_b;
    logic [CNT_W-1:0] snap_c;
    logic [CNT_W-1:0] snap_d;
    logic             snap_vld;
    logic             quiet;
    logic [2:0]       ovf;

    modport master (
        output en, clr, snap, i,
        input  y, snap_b, snap_c, snap_d, snap_vld, quiet, ovf
    );

    modport slave (
        input  en, clr, snap, i,
        output y, snap_b, snap_c, snap_d, snap_vld, quiet, ovf
    );
endinterface

// File: rtl/change_event_counter.sv
// change_event_counter
//   Monitors a WIDTH-bit bus and keeps three chained event counters:
//     B counts input changes, C counts input changes or B changes,
//     D counts B changes or C changes. Each counter moves at most once
//     per edge. Counters wrap (SAT=0) or saturate at all-ones (SAT=1).
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - change_event_counter_if.slave: en, clr, i, snap in;
//            y (live D), snap_b/c/d, snap_vld, quiet, ovf out.
//   Optional feature: define CHANGE_EVENT_COUNTER_OVF_EN to implement the
//   sticky overflow flags {D,C,B}; otherwise ovf is tied to zero.
module change_event_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int SAT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    change_event_counter_if.slave bus
);

    logic [WIDTH-1:0] i_q_q,    i_q_d;
    logic [CNT_W-1:0] cnt_b_q,  cnt_b_d;
    logic [CNT_W-1:0] cnt_c_q,  cnt_c_d;
    logic [CNT_W-1:0] cnt_d_q,  cnt_d_d;
    logic             b_chg_q,  b_chg_d;
    logic             c_chg_q,  c_chg_d;
    logic [CNT_W-1:0] snap_b_q, snap_b_d;
    logic [CNT_W-1:0] snap_c_q, snap_c_d;
    logic [CNT_W-1:0] snap_d_q, snap_d_d;
    logic             snap_vld_q, snap_vld_d;
    logic             quiet_q,  quiet_d;
`ifdef CHANGE_EVENT_COUNTER_OVF_EN
    logic [2:0]       ovf_q,    ovf_d;
`endif

    logic ev;
    logic req_b, req_c, req_d;

    // One-step increment honouring wrap/saturate; a saturated counter
    // returns its own value, so the caller sees "no change".
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v,
                                              input logic             req);
        if (!req)
            return v;
        if (&v)
            return (SAT != 0) ? v : '0;
        return v + CNT_W'(1);
    endfunction

    always_comb begin
        i_q_d      = i_q_q;
        cnt_b_d    = cnt_b_q;
        cnt_c_d    = cnt_c_q;
        cnt_d_d    = cnt_d_q;
        b_chg_d    = b_chg_q;
        c_chg_d    = c_chg_q;
        snap_b_d   = snap_b_q;
        snap_c_d   = snap_c_q;
        snap_d_d   = snap_d_q;
        snap_vld_d = bus.snap;
`ifdef CHANGE_EVENT_COUNTER_OVF_EN
        ovf_d      = ovf_q;
`endif
        ev    = bus.en && (bus.i != i_q_q);
        req_b = ev;
        req_c = ev || b_chg_q;
        req_d = b_chg_q || c_chg_q;

        // Snapshot sees pre-edge counters regardless of en/clr.
        if (bus.snap) begin
            snap_b_d = cnt_b_q;
            snap_c_d = cnt_c_q;
            snap_d_d = cnt_d_q;
        end

        // i_q tracks the bus on every enabled edge, even while clearing.
        if (bus.en)
            i_q_d = bus.i;

        if (bus.clr) begin
            cnt_b_d = '0;
            cnt_c_d = '0;
            cnt_d_d = '0;
            b_chg_d = 1'b0;
            c_chg_d = 1'b0;
`ifdef CHANGE_EVENT_COUNTER_OVF_EN
            ovf_d   = 3'b000;
`endif
        end else if (bus.en) begin
            cnt_b_d = bump(cnt_b_q, req_b);
            cnt_c_d = bump(cnt_c_q, req_c);
            cnt_d_d = bump(cnt_d_q, req_d);
            // Propagate only real value changes; a stuck saturated counter
            // must not keep feeding the next stage.
            b_chg_d = (cnt_b_d != cnt_b_q);
            c_chg_d = (cnt_c_d != cnt_c_q);
`ifdef CHANGE_EVENT_COUNTER_OVF_EN
            ovf_d   = ovf_q | {req_d && (&cnt_d_q),
                               req_c && (&cnt_c_q),
                               req_b && (&cnt_b_q)};
`endif
        end

        quiet_d = !b_chg_d && !c_chg_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q_q      <= '0;
            cnt_b_q    <= '0;
            cnt_c_q    <= '0;
            cnt_d_q    <= '0;
            b_chg_q    <= 1'b0;
            c_chg_q    <= 1'b0;
            snap_b_q   <= '0;
            snap_c_q   <= '0;
            snap_d_q   <= '0;
            snap_vld_q <= 1'b0;
            quiet_q    <= 1'b1;
`ifdef CHANGE_EVENT_COUNTER_OVF_EN
            ovf_q      <= 3'b000;
`endif
        end else begin
            i_q_q      <= i_q_d;
            cnt_b_q    <= cnt_b_d;
            cnt_c_q    <= cnt_c_d;
            cnt_d_q    <= cnt_d_d;
            b_chg_q    <= b_chg_d;
            c_chg_q    <= c_chg_d;
            snap_b_q   <= snap_b_d;
            snap_c_q   <= snap_c_d;
            snap_d_q   <= snap_d_d;
            snap_vld_q <= snap_vld_d;
            quiet_q    <= quiet_d;
`ifdef CHANGE_EVENT_COUNTER_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign bus.y        = cnt_d_q;
    assign bus.snap_b   = snap_b_q;
    assign bus.snap_c   = snap_c_q;
    assign bus.snap_d   = snap_d_q;
    assign bus.snap_vld = snap_vld_q;
    assign bus.quiet    = quiet_q;
`ifdef CHANGE_EVENT_COUNTER_OVF_EN
    assign bus.ovf      = ovf_q;
`else
    assign bus.ovf      = 3'b000;
`endif

endmodule

// File: tb/tb_change_event_counter.sv
// Bench for change_event_counter: a wrapping (SAT=0) and a saturating
// (SAT=1) instance share one stimulus stream; an event-level model of the
// counter chain is checked against both on every falling edge, and a few
// directed scenarios pin literal values.
module tb_change_event_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, clr = 1'b0, snap = 1'b0;
    logic [3:0] i = 4'd0;
    int         nerr = 0, nchk = 0;
    bit         started = 1'b0;

    always #5 clk = ~clk;

    change_event_counter_if #(.WIDTH(4), .CNT_W(4)) b0 ();
    change_event_counter_if #(.WIDTH(4), .CNT_W(4)) b1 ();

    assign b0.en = en;  assign b0.clr = clr;  assign b0.snap = snap;  assign b0.i = i;
    assign b1.en = en;  assign b1.clr = clr;  assign b1.snap = snap;  assign b1.i = i;

    change_event_counter #(.WIDTH(4), .CNT_W(4), .SAT(0)) u_wrap (.clk(clk), .rst(rst), .bus(b0));
    change_event_counter #(.WIDTH(4), .CNT_W(4), .SAT(1)) u_sat  (.clk(clk), .rst(rst), .bus(b1));

    // ---------------- reference model (index 0 = wrap, 1 = saturate)
    int mb[2], mc[2], md[2], msb[2], msc[2], msd[2];
    bit mbc[2], mcc[2];
    bit [2:0] movf[2];
    bit msv;
    int mi;

    function automatic int step_cnt(input int v, input bit req, input int s, output bit o);
        o = req && (v == 15);
        if (!req) return v;
        if (s == 1) return (v + 1 > 15) ? 15 : v + 1;
        return (v + 1) % 16;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                mb[s] = 0; mc[s] = 0; md[s] = 0; msb[s] = 0; msc[s] = 0; msd[s] = 0;
                mbc[s] = 0; mcc[s] = 0; movf[s] = 0;
            end
            msv = 0; mi = 0;
        end else begin
            msv = snap;
            for (int s = 0; s < 2; s++) begin
                if (snap) begin msb[s] = mb[s]; msc[s] = mc[s]; msd[s] = md[s]; end
                if (clr) begin
                    mb[s] = 0; mc[s] = 0; md[s] = 0; mbc[s] = 0; mcc[s] = 0; movf[s] = 0;
                end else if (en) begin
                    bit e, ob, oc, od;
                    int nb, nc, nd;
                    e  = (int'(i) != mi);
                    nb = step_cnt(mb[s], e, s, ob);
                    nc = step_cnt(mc[s], e || mbc[s], s, oc);
                    nd = step_cnt(md[s], mbc[s] || mcc[s], s, od);
                    mbc[s] = (nb != mb[s]);
                    mcc[s] = (nc != mc[s]);
                    mb[s] = nb; mc[s] = nc; md[s] = nd;
                    movf[s] = movf[s] | {od, oc, ob};
                end
            end
            if (en) mi = int'(i);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_one(input int s, input int y, input int sb, input int sc, input int sd,
                           input int sv, input int q, input int ov);
        int eovf;
`ifdef CHANGE_EVENT_COUNTER_OVF_EN
        eovf = int'(movf[s]);
`else
        eovf = 0;
`endif
        chk($sformatf("model y[%0d]", s), y, md[s]);
        chk($sformatf("model snap_b[%0d]", s), sb, msb[s]);
        chk($sformatf("model snap_c[%0d]", s), sc, msc[s]);
        chk($sformatf("model snap_d[%0d]", s), sd, msd[s]);
        chk($sformatf("model snap_vld[%0d]", s), sv, int'(msv));
        chk($sformatf("model quiet[%0d]", s), q, int'(!mbc[s] && !mcc[s]));
        chk($sformatf("model ovf[%0d]", s), ov, eovf);
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp_one(0, int'(b0.y), int'(b0.snap_b), int'(b0.snap_c), int'(b0.snap_d),
                    int'(b0.snap_vld), int'(b0.quiet), int'(b0.ovf));
            cmp_one(1, int'(b1.y), int'(b1.snap_b), int'(b1.snap_c), int'(b1.snap_d),
                    int'(b1.snap_vld), int'(b1.quiet), int'(b1.ovf));
        end
    end

    // ---------------- stimulus
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Snapshot the wrap instance and pin its captured B/C/D.
    task automatic snap_chk(input string name, input int eb, input int ec, input int ed);
        snap = 1'b1; tick(); snap = 1'b0;
        chk({name, " snap_vld"}, int'(b0.snap_vld), 1);
        chk({name, " snap_b"}, int'(b0.snap_b), eb);
        chk({name, " snap_c"}, int'(b0.snap_c), ec);
        chk({name, " snap_d"}, int'(b0.snap_d), ed);
    endtask

    task automatic do_clr(input logic [3:0] iv);
        i = iv; en = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        started = 1'b1;
        // reset state
        chk("reset y", int'(b0.y), 0);
        chk("reset quiet", int'(b0.quiet), 1);
        chk("reset snap_vld", int'(b0.snap_vld), 0);
        chk("reset ovf", int'(b0.ovf), 0);

        // single change 0 -> 5
        i = 4'd5; en = 1'b1; tick();
        chk("single quiet low", int'(b0.quiet), 0);
        tick(2);
        chk("single y", int'(b0.y), 2);
        chk("single quiet back", int'(b0.quiet), 1);
        snap_chk("single", 1, 2, 2);
        tick();
        chk("single snap_vld drop", int'(b0.snap_vld), 0);

        // change every cycle 0->1->2->3->4
        do_clr(4'd0);
        for (int k = 1; k <= 4; k++) begin i = 4'(k); tick(); end
        tick(3);
        snap_chk("burst", 4, 5, 5);

        // toggles while disabled count as one event
        do_clr(4'd4);
        en = 1'b0;
        i = 4'd7; tick(); i = 4'd2; tick(); i = 4'd9; tick();
        en = 1'b1; tick(4);
        snap_chk("disabled", 1, 2, 2);

        // clr during propagation
        do_clr(4'd9);
        i = 4'd3; tick();
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr y", int'(b0.y), 0);
        chk("clr quiet", int'(b0.quiet), 1);
        tick(3);
        chk("clr y later", int'(b0.y), 0);
        snap_chk("clr", 0, 0, 0);

        // snapshot at the edge where B goes 0 -> 1, then two cycles later
        do_clr(4'd3);
        i = 4'd6; snap = 1'b1; tick(); snap = 1'b0;
        chk("snapA vld", int'(b0.snap_vld), 1);
        chk("snapA b", int'(b0.snap_b), 0);
        tick();
        chk("snapA vld pulse", int'(b0.snap_vld), 0);
        snap_chk("snapB", 1, 2, 1);

        // 16 isolated changes: wrap vs saturate
        do_clr(4'd0);
        for (int k = 0; k < 16; k++) begin i = (k % 2 == 0) ? 4'd1 : 4'd0; tick(4); end
        snap = 1'b1; tick(); snap = 1'b0;
        chk("wrap B", int'(b0.snap_b), 0);
        chk("sat B", int'(b1.snap_b), 15);
        chk("sat quiet", int'(b1.quiet), 1);
`ifdef CHANGE_EVENT_COUNTER_OVF_EN
        chk("wrap ovf B", int'(b0.ovf[0]), 1);
`else
        chk("ovf tied", int'(b0.ovf), 0);
`endif

        // randomized traffic checked by the model each cycle
        for (int k = 0; k < 1500; k++) begin
            rst  = ($urandom_range(0, 199) == 0);
            en   = ($urandom_range(0, 9) < 8);
            clr  = ($urandom_range(0, 39) == 0);
            snap = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) i = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0; en = 1'b0; clr = 1'b0; snap = 1'b0;
        tick();
        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
